// File: rtl/cpu_td_pkg.sv
// ---------------------------------------------------------------------------
// cpu_td_pkg
//   Shared definitions for the cpu_td accumulator CPU.
//   - OPC_W    : width of the opcode field at the top of each instruction word
//   - opcode_e : the instruction set. Any code not listed here executes as a
//                NOP: PC advances and A, B, C and led all hold.
// ---------------------------------------------------------------------------
package cpu_td_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD_A     = 4'b0000,  // A <= A + imm, C <= carry out
      OP_MOV_A_B   = 4'b0001,  // A <= B
      OP_IN_A      = 4'b0010,  // A <= sw
      OP_MOV_A_IMM = 4'b0011,  // A <= imm
      OP_MOV_B_A   = 4'b0100,  // B <= A
      OP_ADD_B     = 4'b0101,  // B <= B + imm, C <= carry out
      OP_IN_B      = 4'b0110,  // B <= sw
      OP_MOV_B_IMM = 4'b0111,  // B <= imm
      OP_OUT_B     = 4'b1001,  // led <= B
      OP_OUT_IMM   = 4'b1011,  // led <= imm
      OP_JNC       = 4'b1110,  // PC <= imm when C == 0
      OP_JMP       = 4'b1111   // PC <= imm
   } opcode_e;

endpackage

// File: rtl/cpu_td_reg_n.sv
// ---------------------------------------------------------------------------
// reg_n
//   W-bit register with load enable and an asynchronous active-low clear.
//   It is the architectural storage element of cpu_td: one instance each
//   holds A, B, led, PC and the carry flag (W = 1).
// Ports
//   clk    in  1   rising-edge clock
//   n_rst  in  1   asynchronous active-low clear (q -> 0 immediately)
//   en     in  1   load enable; q holds when low
//   d      in  W   next value
//   q      out W   current value
// ---------------------------------------------------------------------------
module reg_n #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/cpu_td.sv
// ---------------------------------------------------------------------------
// cpu_td
//   Single-cycle accumulator CPU. Every rising clock edge retires exactly one
//   instruction fetched from an external combinational ROM; there is no
//   pipeline and no stall. This module is only the datapath glue: decode,
//   the shared adder and the next-PC mux. All state lives in reg_n instances.
// Parameters
//   DATA_W  width of A, B, the immediate field, sw and led
//   ADDR_W  PC / ROM address width
// Ports
//   clk    in  1        rising-edge clock
//   n_rst  in  1        asynchronous active-low reset (A, B, C, PC, led -> 0)
//   data   in  INSTR_W  instruction word at addr: {opcode[3:0], imm[DATA_W-1:0]}
//   addr   out ADDR_W   instruction address, equal to PC
//   sw     in  DATA_W   switch input, read only by IN A / IN B
//   led    out DATA_W   output port register, written only by OUT
// ---------------------------------------------------------------------------
module cpu_td
   import cpu_td_pkg::*;
#(
   parameter int  DATA_W  = 4,
   parameter int  ADDR_W  = 4,
   localparam int INSTR_W = OPC_W + DATA_W
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [INSTR_W-1:0] data,
   output logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  sw,
   output logic [DATA_W-1:0]  led
);

   // ------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------
   opcode_e           opc;
   logic [DATA_W-1:0] imm;

   assign opc = opcode_e'(data[INSTR_W-1 -: OPC_W]);
   assign imm = data[DATA_W-1:0];

   // ------------------------------------------------------------------
   // Architectural state (current values and next-state/enables)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] a_q,   a_d;
   logic [DATA_W-1:0] b_q,   b_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic [ADDR_W-1:0] pc_q,  pc_d;
   logic              c_q,   c_d;
   logic              a_en, b_en, led_en, c_en;

   // ------------------------------------------------------------------
   // Shared adder: ADD A and ADD B are the only users, so a single
   // DATA_W+1 bit adder with an operand mux serves both. The top bit is
   // the carry out; the low bits are the wrapped result.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] add_src;
   logic [DATA_W:0]   sum;

   assign add_src = (opc == OP_ADD_B) ? b_q : a_q;
   assign sum     = {1'b0, add_src} + {1'b0, imm};

   // ------------------------------------------------------------------
   // Jump target: immediate fitted to the PC width. A wider immediate is
   // truncated to its low bits, a narrower one is zero-extended.
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] jmp_target;
   logic [ADDR_W-1:0] pc_inc;

   generate
      if (DATA_W >= ADDR_W) begin : g_target_trunc
         assign jmp_target = imm[ADDR_W-1:0];
      end else begin : g_target_zext
         assign jmp_target = {{(ADDR_W - DATA_W){1'b0}}, imm};
      end
   endgenerate

   // Natural wrap from all-ones back to zero.
   assign pc_inc = pc_q + ADDR_W'(1);

   // ------------------------------------------------------------------
   // Decode. Every listed opcode clears C unless it is an ADD, which
   // writes the carry out instead; an unknown opcode leaves C alone,
   // which is why c_en is dropped only in the default branch.
   // ------------------------------------------------------------------
   always_comb begin
      a_en   = 1'b0;
      a_d    = sum[DATA_W-1:0];
      b_en   = 1'b0;
      b_d    = sum[DATA_W-1:0];
      led_en = 1'b0;
      led_d  = b_q;
      c_en   = 1'b1;
      c_d    = 1'b0;
      pc_d   = pc_inc;

      case (opc)
         OP_ADD_A: begin
            a_en = 1'b1;
            c_d  = sum[DATA_W];
         end
         OP_ADD_B: begin
            b_en = 1'b1;
            c_d  = sum[DATA_W];
         end
         OP_MOV_A_IMM: begin
            a_en = 1'b1;
            a_d  = imm;
         end
         OP_MOV_B_IMM: begin
            b_en = 1'b1;
            b_d  = imm;
         end
         OP_MOV_A_B: begin
            a_en = 1'b1;
            a_d  = b_q;
         end
         OP_MOV_B_A: begin
            b_en = 1'b1;
            b_d  = a_q;
         end
         OP_IN_A: begin
            a_en = 1'b1;
            a_d  = sw;
         end
         OP_IN_B: begin
            b_en = 1'b1;
            b_d  = sw;
         end
         OP_OUT_B: begin
            led_en = 1'b1;
            led_d  = b_q;
         end
         OP_OUT_IMM: begin
            led_en = 1'b1;
            led_d  = imm;
         end
         OP_JMP: begin
            pc_d = jmp_target;
         end
         OP_JNC: begin
            // Tests the registered flag, i.e. the carry left by the
            // previous instruction.
            if (!c_q) begin
               pc_d = jmp_target;
            end
         end
         default: begin
            c_en = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   reg_n #(.W(DATA_W)) u_reg_a (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (a_en),
      .d     (a_d),
      .q     (a_q)
   );

   reg_n #(.W(DATA_W)) u_reg_b (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (b_en),
      .d     (b_d),
      .q     (b_q)
   );

   reg_n #(.W(DATA_W)) u_reg_led (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (led_en),
      .d     (led_d),
      .q     (led_q)
   );

   // PC advances on every edge, so its enable is tied high.
   reg_n #(.W(ADDR_W)) u_reg_pc (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (1'b1),
      .d     (pc_d),
      .q     (pc_q)
   );

   reg_n #(.W(1)) u_reg_c (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (c_en),
      .d     (c_d),
      .q     (c_q)
   );

   assign addr = pc_q;
   assign led  = led_q;

endmodule

// File: tb/tb_cpu_td.sv
// ---------------------------------------------------------------------------
// tb_cpu_td
//   Self-checking bench for cpu_td (DATA_W = ADDR_W = 4). A ROM array inside
//   the bench feeds the CPU; a behavioural instruction-set model, written
//   with plain integer arithmetic, predicts PC, A, B, C and led after every
//   clock. Directed programs cover the documented scenarios, then random
//   programs with random switch values and random asynchronous resets run.
// ---------------------------------------------------------------------------
module tb_cpu_td;

   localparam int DW  = 4;
   localparam int AW  = 4;
   localparam int IW  = 4 + DW;
   localparam int DMOD = 1 << DW;
   localparam int AMOD = 1 << AW;

   logic          clk;
   logic          n_rst;
   logic [IW-1:0] data;
   logic [AW-1:0] addr;
   logic [DW-1:0] sw;
   logic [DW-1:0] led;

   logic [IW-1:0] rom [AMOD];

   int n_cmp;
   int n_err;

   // reference model state
   int m_a, m_b, m_c, m_pc, m_led;

   assign data = rom[addr];

   cpu_td #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .data  (data),
      .addr  (addr),
      .sw    (sw),
      .led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (got running, want finished)");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".addr"}, int'(addr),      m_pc);
      check({tag, ".led"},  int'(led),       m_led);
      check({tag, ".a"},    int'(dut.a_q),   m_a);
      check({tag, ".b"},    int'(dut.b_q),   m_b);
      check({tag, ".c"},    int'(dut.c_q),   m_c);
   endtask

   // ------------------------------------------------------------------
   // Reference model: one instruction per call
   // ------------------------------------------------------------------
   task automatic model_step(input int instr, input int swv);
      int op, imm, s, npc;
      op  = (instr >> DW) & 15;
      imm = instr % DMOD;
      npc = (m_pc + 1) % AMOD;
      case (op)
         0:  begin s = m_a + imm; m_a = s % DMOD; m_c = (s >= DMOD) ? 1 : 0; end
         5:  begin s = m_b + imm; m_b = s % DMOD; m_c = (s >= DMOD) ? 1 : 0; end
         3:  begin m_a = imm;   m_c = 0; end
         7:  begin m_b = imm;   m_c = 0; end
         1:  begin m_a = m_b;   m_c = 0; end
         4:  begin m_b = m_a;   m_c = 0; end
         2:  begin m_a = swv;   m_c = 0; end
         6:  begin m_b = swv;   m_c = 0; end
         9:  begin m_led = m_b; m_c = 0; end
         11: begin m_led = imm; m_c = 0; end
         15: begin npc = imm % AMOD; m_c = 0; end
         14: begin if (m_c == 0) npc = imm % AMOD; m_c = 0; end
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_c = 0; m_pc = 0; m_led = 0;
   endtask

   // One clock: drive sw at the falling edge, sample 1 ns after the rise.
   task automatic step(input string tag, input int swv);
      @(negedge clk);
      sw = DW'(swv);
      model_step(int'(rom[m_pc]), swv);
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   // Asynchronous reset asserted 2 ns after a rising edge (mid-cycle),
   // held across one rising edge, released away from any edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      model_reset();
      check_state({tag, ".rst_now"});
      @(posedge clk);
      #1;
      check_state({tag, ".rst_held"});
      #1;
      n_rst = 1'b1;
   endtask

   task automatic load_nops();
      for (int i = 0; i < AMOD; i++) rom[i] = 8'h80;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      n_rst = 1'b0;
      sw    = '0;
      load_nops();
      model_reset();
      #1;
      check_state("por");
      #10;
      n_rst = 1'b1;

      // ---- ADD / carry, then JNC fall-through and taken ----
      load_nops();
      rom[0] = 8'h3E;  // MOV A,E
      rom[1] = 8'h01;  // ADD A,1
      rom[2] = 8'h01;  // ADD A,1
      rom[3] = 8'hE9;  // JNC 9  (C=1, falls through)
      rom[4] = 8'hE9;  // JNC 9  (C=0, taken)
      async_reset("add");
      step("add.mov", 0);
      step("add.1", 0);
      check("add.a_is_f", int'(dut.a_q), 15);
      check("add.c_is_0", int'(dut.c_q), 0);
      step("add.2", 0);
      check("add.a_wrap", int'(dut.a_q), 0);
      check("add.c_is_1", int'(dut.c_q), 1);
      step("jnc.fall", 0);
      check("jnc.fall_addr", int'(addr), 4);
      step("jnc.taken", 0);
      check("jnc.taken_addr", int'(addr), 9);

      // ---- moves and I/O ----
      load_nops();
      rom[0] = 8'h20;  // IN A
      rom[1] = 8'h40;  // MOV B,A
      rom[2] = 8'h90;  // OUT B
      rom[3] = 8'hBA;  // OUT A(imm)
      async_reset("io");
      step("io.in", 5);
      step("io.mov", 5);
      step("io.outb", 5);
      check("io.led5", int'(led), 5);
      step("io.outi", 5);
      check("io.ledA", int'(led), 10);
      check("io.b5", int'(dut.b_q), 5);

      // ---- PC wrap with NOPs ----
      load_nops();
      async_reset("wrap");
      for (int k = 1; k <= AMOD + 1; k++) begin
         step("wrap", 0);
         check("wrap.addr", int'(addr), k % AMOD);
      end

      // ---- LED counter loop ----
      load_nops();
      rom[0] = 8'h90;  // OUT B
      rom[1] = 8'h51;  // ADD B,1
      rom[2] = 8'hF0;  // JMP 0
      async_reset("loop");
      for (int k = 0; k < 3 * (DMOD + 1); k++) begin
         step("loop", 0);
         if (k % 3 == 0) check("loop.led", int'(led), (k / 3) % DMOD);
         if (k == 3 * (DMOD - 1) + 1) check("loop.carry", int'(dut.c_q), 1);
      end

      // ---- random programs, random sw, random async resets ----
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < AMOD; i++) rom[i] = IW'($urandom);
         async_reset("rnd");
         for (int n = 0; n < 150; n++) begin
            step("rnd", int'($urandom_range(DMOD - 1, 0)));
            if ($urandom_range(39, 0) == 0) async_reset("rnd.mid");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
